// File: rtl/ifetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave). One outstanding request at a time.
interface ifetch_if #(
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 32
);
  logic               o_imem_req;
  logic [NB_ADDR-1:0] o_imem_addr;
  logic               i_imem_gnt;
  logic               i_imem_rvalid;
  logic [NB_WORD-1:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_gnt,
    input  i_imem_rvalid,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_gnt,
    output i_imem_rvalid,
    output i_imem_rdata
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, single-outstanding fetch FSM and a
// one-entry output register to decode. IFETCH_MISALIGN_TRAP_EN enables the misaligned-PC trap.
module ifetch #(
  parameter int                 NB_WORD  = 32,
  parameter int                 NB_ADDR  = 32,
  parameter logic [NB_ADDR-1:0] RESET_PC = NB_ADDR'(32'h0000_0000)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  ifetch_if.master           imem,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [NB_ADDR-1:0] i_redirect_addr,
  output logic               o_valid,
  output logic [NB_WORD-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic               o_misaligned
`endif
);

  typedef enum logic [1:0] {
    ST_REQ       = 2'd0,
    ST_WAIT      = 2'd1,
    ST_WAIT_DROP = 2'd2
  } state_e;

  localparam logic [NB_WORD-1:0] NOP     = NB_WORD'(32'h0000_0013);
  localparam logic [NB_ADDR-1:0] PC_STEP = NB_ADDR'(32'd4);

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [NB_WORD-1:0] instr_q, instr_d;
  logic [NB_ADDR-1:0] opc_q, opc_d;
  logic               req_s;
  logic               free_s;
  logic [NB_ADDR-1:0] redir_pc_s;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic               mis_q, mis_d;
  logic               trap_q, trap_d;

  assign redir_pc_s = i_redirect_addr;
`else
  logic               unused_redir_lsb_s;

  assign redir_pc_s         = {i_redirect_addr[NB_ADDR-1:2], 2'b00};
  assign unused_redir_lsb_s = ^i_redirect_addr[1:0];
`endif

  // Output register can take a new fetch when empty or drained this cycle.
  assign free_s = !valid_q || !i_stall;

  // Next-state, PC and output-register update; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    req_s   = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
    trap_d  = trap_q;
`endif
    if (i_redirect) begin
      pc_d    = redir_pc_s;
      valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_d   = 1'b0;
      trap_d  = 1'b0;
`endif
      // A response still owed by memory must be swallowed before refetching.
      if ((state_q != ST_REQ) && !imem.i_imem_rvalid) begin
        state_d = ST_WAIT_DROP;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      if (valid_q && !i_stall) begin
        valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
      end else begin
        valid_d = valid_q;
      end
      case (state_q)
        ST_REQ: begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (pc_q[1:0] != 2'b00) begin
            if (!trap_q && free_s) begin
              valid_d = 1'b1;
              mis_d   = 1'b1;
              instr_d = NOP;
              opc_d   = pc_q;
              trap_d  = 1'b1;
            end else begin
              trap_d  = trap_q;
            end
          end else begin
`endif
            req_s = free_s;
            if (req_s && imem.i_imem_gnt) begin
              state_d = ST_WAIT;
            end else begin
              state_d = ST_REQ;
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
          end
`endif
        end
        ST_WAIT: begin
          if (imem.i_imem_rvalid) begin
            instr_d = imem.i_imem_rdata;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_STEP;
            state_d = ST_REQ;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT_DROP: begin
          if (imem.i_imem_rvalid) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_WAIT_DROP;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  // State, PC and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      opc_q   <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
      trap_q  <= trap_d;
`endif
    end
  end

  // Request is held low throughout reset so memory never sees a stray fetch.
  assign imem.o_imem_req  = req_s && i_reset;
  assign imem.o_imem_addr = pc_q;
  assign o_valid          = valid_q;
  assign o_instruction    = instr_q;
  assign o_pc             = opc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign o_misaligned     = mis_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed cycle table, reset-mid-request sequence, then
// randomized traffic against an in-order delivery scoreboard and memory model.
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int NVEC = 28;
  localparam int NRAND = 3000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redir_addr;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        o_misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  ifetch_if #(.NB_WORD(32), .NB_ADDR(32)) bus ();

  ifetch #(.NB_WORD(32), .NB_ADDR(32), .RESET_PC(32'h0000_0000)) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .imem           (bus.master),
    .i_stall        (stall),
    .i_redirect     (redirect),
    .i_redirect_addr(redir_addr),
    .o_valid        (o_valid),
    .o_instruction  (o_instruction),
    .o_pc           (o_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .o_misaligned   (o_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] raddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    else if (a == 32'h0000_0004) return 32'h00A0_0113;
    else return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] ra,
                              input logic g, input logic rv, input logic [31:0] rd,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei, input logic em);
    vec_t v;
    v.stall = s; v.redir = r; v.raddr = ra; v.gnt = g; v.rvalid = rv; v.rdata = rd;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},   {31'd0, bus.o_imem_req}, 32'd0);
    chk({tag, "_addr"},  bus.o_imem_addr, 32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_pc"},    o_pc, 32'h0000_0000);
    chk({tag, "_instr"}, o_instruction, NOP);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard / memory model state for the random phase
  logic [31:0] exp_pc;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          delivered;
  logic        hold_prev;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic [31:0] base;

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redir_addr = 32'h0;
    bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = 32'h0;

    // stall, redir, raddr, gnt, rvalid, rdata | req, addr, valid, pc, instr, mis
    vecs[0]  = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0,1'b0,32'h0,NOP,1'b0);
    vecs[1]  = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'h0050_0093,  1'b0,32'h0,1'b0,32'h0,NOP,1'b0);
    vecs[2]  = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h4,1'b1,32'h0,32'h0050_0093,1'b0);
    vecs[3]  = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'h00A0_0113,  1'b0,32'h4,1'b0,32'h0,32'h0050_0093,1'b0);
    vecs[4]  = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h8,1'b1,32'h4,32'h00A0_0113,1'b0);
    vecs[5]  = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'hC0DE_0008,  1'b0,32'h8,1'b0,32'h4,32'h00A0_0113,1'b0);
    vecs[6]  = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'hC,1'b1,32'h8,32'hC0DE_0008,1'b0);
    vecs[7]  = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'hC,1'b1,32'h8,32'hC0DE_0008,1'b0);
    vecs[8]  = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'hC,1'b1,32'h8,32'hC0DE_0008,1'b0);
    vecs[9]  = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'hC,1'b1,32'h8,32'hC0DE_0008,1'b0);
    vecs[10] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'hC0DE_000C,  1'b0,32'hC,1'b0,32'h8,32'hC0DE_0008,1'b0);
    vecs[11] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h10,1'b1,32'hC,32'hC0DE_000C,1'b0);
    vecs[12] = mk(1'b0,1'b1,32'h100,1'b0,1'b0,32'h0,        1'b0,32'h10,1'b0,32'hC,32'hC0DE_000C,1'b0);
    vecs[13] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h100,1'b0,32'hC,32'hC0DE_000C,1'b0);
    vecs[14] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'hC0DE_0010,  1'b0,32'h100,1'b0,32'hC,32'hC0DE_000C,1'b0);
    vecs[15] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h100,1'b0,32'hC,32'hC0DE_000C,1'b0);
    vecs[16] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'hC0DE_0100,  1'b0,32'h100,1'b0,32'hC,32'hC0DE_000C,1'b0);
    vecs[17] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h104,1'b1,32'h100,32'hC0DE_0100,1'b0);
    vecs[18] = mk(1'b0,1'b1,32'h200,1'b0,1'b1,32'hC0DE_0104,1'b0,32'h104,1'b0,32'h100,32'hC0DE_0100,1'b0);
    vecs[19] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h200,1'b0,32'h100,32'hC0DE_0100,1'b0);
    vecs[20] = mk(1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b0,32'h0,  1'b0,32'h200,1'b0,32'h100,32'hC0DE_0100,1'b0);
    vecs[21] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'hFFFF_FFFC,1'b0,32'h100,32'hC0DE_0100,1'b0);
    vecs[22] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'h3F21_FFFC,  1'b0,32'hFFFF_FFFC,1'b0,32'h100,32'hC0DE_0100,1'b0);
    vecs[23] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0,1'b1,32'hFFFF_FFFC,32'h3F21_FFFC,1'b0);
    vecs[24] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'h0050_0093,  1'b0,32'h0,1'b0,32'hFFFF_FFFC,32'h3F21_FFFC,1'b0);
    vecs[25] = mk(1'b0,1'b1,32'h102,1'b0,1'b0,32'h0,        1'b0,32'h4,1'b1,32'h0,32'h0050_0093,1'b0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    vecs[26] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h102,1'b0,32'h0,32'h0050_0093,1'b0);
    vecs[27] = mk(1'b0,1'b1,32'h300,1'b0,1'b0,32'h0,        1'b0,32'h102,1'b1,32'h102,NOP,1'b1);
`else
    vecs[26] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h100,1'b0,32'h0,32'h0050_0093,1'b0);
    vecs[27] = mk(1'b0,1'b1,32'h300,1'b0,1'b0,32'h0,        1'b0,32'h100,1'b0,32'h0,32'h0050_0093,1'b0);
`endif

    // reset values while held in reset
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state("reset");
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("reset_mis", {31'd0, o_misaligned}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // directed cycle table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      stall = vecs[i].stall; redirect = vecs[i].redir; redir_addr = vecs[i].raddr;
      bus.i_imem_gnt = vecs[i].gnt; bus.i_imem_rvalid = vecs[i].rvalid;
      bus.i_imem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i),   {31'd0, bus.o_imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i),  bus.o_imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, o_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_pc", i),    o_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), o_instruction, vecs[i].e_instr);
`ifdef IFETCH_MISALIGN_TRAP_EN
      chk($sformatf("v%0d_mis", i),   {31'd0, o_misaligned}, {31'd0, vecs[i].e_mis});
`endif
    end

    // reset asserted while a request is outstanding: response is abandoned
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0; bus.i_imem_gnt = 1'b1; bus.i_imem_rvalid = 1'b0;
    #1;
    chk("midrst_req", {31'd0, bus.o_imem_req}, 32'd1);
    chk("midrst_addr", bus.o_imem_addr, 32'h300);
    @(negedge clk);
    bus.i_imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_req", {31'd0, bus.o_imem_req}, 32'd1);
    chk("postrst_addr", bus.o_imem_addr, 32'h0);

    // randomized traffic against the delivery scoreboard
    exp_pc = 32'h0; pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0;
    delivered = 0; hold_prev = 1'b0; prev_pc = 32'h0; prev_instr = 32'h0;
    for (int c = 0; c < NRAND; c++) begin
      @(negedge clk);
      if (hold_prev) begin
        chk("hold_valid", {31'd0, o_valid}, 32'd1);
        chk("hold_pc", o_pc, prev_pc);
        chk("hold_instr", o_instruction, prev_instr);
      end
      stall    = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 15) == 0);
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0000_1000;
`ifdef IFETCH_MISALIGN_TRAP_EN
      redir_addr = base + 32'($urandom_range(0, 3) * 4);
`else
      redir_addr = base + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
`endif
      bus.i_imem_rvalid = pend && (pend_cnt == 0);
      bus.i_imem_rdata  = bus.i_imem_rvalid ? mem_word(pend_addr) : $urandom;
      #1;
      bus.i_imem_gnt = bus.o_imem_req && ($urandom_range(0, 1) == 1);
      #1;
      if (bus.o_imem_req && pend) begin
        chk("one_outstanding", 32'd1, 32'd0);
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      chk("rand_mis", {31'd0, o_misaligned}, 32'd0);
`endif
      if (!redirect && o_valid && !stall) begin
        chk("deliver_pc", o_pc, exp_pc);
        chk("deliver_instr", o_instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redirect) exp_pc = redir_addr & 32'hFFFF_FFFC;
      hold_prev  = o_valid && stall && !redirect;
      prev_pc    = o_pc;
      prev_instr = o_instruction;
      if (bus.i_imem_rvalid) pend = 1'b0;
      else if (pend) pend_cnt--;
      if (bus.i_imem_gnt) begin
        pend = 1'b1; pend_addr = bus.o_imem_addr; pend_cnt = $urandom_range(0, 2);
      end
    end
    chk("progress", {31'd0, (delivered >= 100)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter NB_WORD, 32, instruction width in bits.
REQ-002 Parameter NB_ADDR, 32, PC and fetch address width in bits.
REQ-003 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be 0.
REQ-004 i_clock  in  1  single clock; all state updates on the rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 o_imem_req  out  1  fetch request to instruction memory.
REQ-007 o_imem_addr  out  NB_ADDR  fetch address, always equals the PC register.
REQ-008 i_imem_gnt  in  1  memory accepts the request this cycle.
REQ-009 i_imem_rvalid  in  1  read data valid.
REQ-010 i_imem_rdata  in  NB_WORD  fetched instruction.
REQ-011 i_stall  in  1  decode cannot accept; hold the output.
REQ-012 i_redirect  in  1  branch/jump taken; flush and refetch.
REQ-013 i_redirect_addr  in  NB_ADDR  new PC on redirect.
REQ-014 o_valid  out  1  o_instruction and o_pc hold a valid fetch for decode.
REQ-015 o_instruction  out  NB_WORD  instruction to decode.
REQ-016 o_pc  out  NB_ADDR  address of o_instruction.

Function
REQ-017 FSM states: REQ, WAIT, WAIT_DROP; at most one outstanding memory request.
REQ-018 REQ: o_imem_req = (!o_valid || !i_stall) && !i_redirect; on i_imem_gnt move to WAIT, else stay in REQ.
REQ-019 WAIT: o_imem_req=0; on i_imem_rvalid, load o_instruction<=i_imem_rdata, o_pc<=PC, o_valid<=1, PC<=PC+4, then move to REQ.
REQ-020 PC+4 SHALL wrap modulo 2^NB_ADDR (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 Output register consumed when o_valid && !i_stall; o_valid then clears unless a new response loads in the same cycle.
REQ-022 While o_valid && i_stall, o_valid, o_instruction and o_pc SHALL hold stable.
REQ-023 Because a request is issued only when the output register is free, a response SHALL never overwrite an unconsumed output.
REQ-024 i_redirect (any state): PC<=i_redirect_addr, o_valid<=0; i_redirect has priority over i_stall and i_imem_rvalid.
REQ-025 Redirect in WAIT without a same-cycle rvalid -> WAIT_DROP; with a same-cycle rvalid -> discard the data, move to REQ.
REQ-026 Redirect in REQ with a same-cycle gnt cannot occur (o_imem_req is forced low by REQ-018); remain in REQ.
REQ-027 WAIT_DROP: on i_imem_rvalid, discard the data, leave PC unchanged, move to REQ; a further redirect here updates PC and stays in WAIT_DROP.
REQ-028 Fetch latency: first o_valid no earlier than 2 cycles after the gnt cycle with zero-wait memory (gnt at cycle n, rvalid at n+1, o_valid at n+2).

Reset
REQ-029 While i_reset=0: PC=RESET_PC, state=REQ, o_valid=0, o_instruction=32'h0000_0013 (NOP), o_pc=RESET_PC, o_imem_req=0.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding request; the bench/memory model SHALL drop the pending response on reset.

Configuration
REQ-031 Macro IFETCH_MISALIGN_TRAP_EN.
REQ-032 Defined: output port o_misaligned (1 bit), reset value 0; a redirect with i_redirect_addr[1:0]!=0 loads PC unmasked; in REQ with PC[1:0]!=0 no request is issued and the block loads o_valid=1, o_misaligned=1, o_instruction=NOP, o_pc=PC, then idles in REQ (no requests) until the next redirect; o_misaligned clears with o_valid.
REQ-033 Not defined: no o_misaligned port; PC<={i_redirect_addr[NB_ADDR-1:2],2'b00}.

Verification
REQ-034 Reset release, zero-wait memory returning 32'h00500093 @0 and 32'h00A00113 @4 -> o_valid with o_pc=0 then o_pc=4, instructions in order.
REQ-035 i_stall held 3 cycles while o_valid=1 at o_pc=8 -> o_valid/o_pc/o_instruction constant, o_imem_req=0, no lost or duplicated fetch.
REQ-036 Redirect to 32'h100 while in WAIT for 0x10, rvalid 2 cycles later -> data for 0x10 dropped; next o_valid has o_pc=32'h100.
REQ-037 Redirect in the same cycle as rvalid -> data dropped, o_valid=0 next cycle, next request address equals the redirect address.
REQ-038 Redirect to 32'hFFFF_FFFC -> fetches at FFFF_FFFC then 0000_0000.
REQ-039 Redirect to 32'h102: with IFETCH_MISALIGN_TRAP_EN -> o_valid=1, o_misaligned=1, o_pc=32'h102, no o_imem_req; without it -> fetch issued at 32'h100.
